// File: rtl/handshake_tx_fifo_if.sv
// Producer/consumer bundle for the handshake feeder FIFO.
// The FIFO sits on the slave modport; the bench or surrounding logic uses master.
interface handshake_tx_fifo_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             full;
    logic [PTR_W:0]   count;
    logic             overflow;
    logic             clr_ovf;
    logic             busy_in;
    logic             valid_out;
    logic [WIDTH-1:0] data_out;

    modport master (
        output wr_en, wr_data, clr_ovf, busy_in,
        input  full, count, overflow, valid_out, data_out
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf, busy_in,
        output full, count, overflow, valid_out, data_out
    );
endinterface

// File: rtl/handshake_tx_fifo.sv
// Circular FIFO feeding the handshake requester: absorbs producer bursts while
// downstream is busy, pops one word per cycle when busy_in is low.
module handshake_tx_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input logic                clk,
    input logic                rstn,
    handshake_tx_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             overflow;
    logic             full, valid, push, pop;

    // Status flags come only from registered count, never from wr_en/busy_in.
    assign full  = (count == FULL_CNT);
    assign valid = (count != '0);
    assign push  = bus.wr_en && !full;
    assign pop   = valid && !bus.busy_in;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
            // A dropped write outranks a same-cycle clear.
            if (bus.wr_en && full) overflow <= 1'b1;
            else if (bus.clr_ovf)  overflow <= 1'b0;
        end
    end

    assign bus.full      = full;
    assign bus.count     = count;
    assign bus.overflow  = overflow;
    assign bus.valid_out = valid;
    // Storage is not reset, so mask the head word while empty.
    assign bus.data_out  = valid ? mem[rd_ptr] : '0;
endmodule
